// File: rtl/falafel_mem_bridge.sv
// falafel_mem_bridge: adapts the allocator memory port to the shared memory bus.
// One-entry request slice, read credit counter, in-order response FIFO.
// Optional macro FALAFEL_MEM_BRIDGE_BYPASS_EN: same-cycle response bypass when FIFO is empty.
module falafel_mem_bridge #(
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 up_req_val_i,
    output logic                                 up_req_rdy_o,
    input  logic                                 up_req_is_write_i,
    input  logic [DATA_W-1:0]                    up_req_addr_i,
    input  logic [DATA_W-1:0]                    up_req_data_i,
    output logic                                 up_rsp_val_o,
    input  logic                                 up_rsp_rdy_i,
    output logic [DATA_W-1:0]                    up_rsp_data_o,
    output logic                                 mem_req_val_o,
    input  logic                                 mem_req_rdy_i,
    output logic                                 mem_req_we_o,
    output logic [DATA_W-1:0]                    mem_req_addr_o,
    output logic [DATA_W-1:0]                    mem_req_wdata_o,
    input  logic                                 mem_rsp_val_i,
    input  logic [DATA_W-1:0]                    mem_rsp_data_i,
    output logic [$clog2(MAX_OUTSTANDING):0]     inflight_o,
    output logic                                 err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned UW = CW + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CW-1:0]       r_inflight;
    logic [CW-1:0]       r_count;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [MAX_OUTSTANDING];
    logic                r_err;

    logic [UW-1:0]       w_used;
    logic                w_credit_ok;
    logic                w_issue;
    logic                w_capture;
    logic                w_rsp_ok;
    logic                w_rsp_orphan;
    logic                w_push;
    logic                w_pop;
    logic                w_overflow;
    logic                w_wr_en;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_rd_inc;

    // Credit accounting: reads on the bus plus words waiting in the FIFO
    assign w_used        = UW'(r_inflight) + UW'(r_count);
    assign w_credit_ok   = (w_used < UW'(MAX_OUTSTANDING));
    assign w_fifo_empty  = (r_count == '0);
    assign w_fifo_full   = (r_count == CW'(MAX_OUTSTANDING));
    assign w_rsp_ok      = mem_rsp_val_i && (r_inflight != '0);
    assign w_rsp_orphan  = mem_rsp_val_i && (r_inflight == '0);
    assign w_rd_inc      = w_issue && !r_we;

    // Slice next-state and handshake decode; reads wait for a free credit
    always_comb begin
        w_state_nxt   = r_state;
        mem_req_val_o = 1'b0;
        up_req_rdy_o  = 1'b0;
        w_issue       = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                up_req_rdy_o = 1'b1;
                w_capture    = up_req_val_i;
                if (up_req_val_i) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                mem_req_val_o = r_we || w_credit_ok;
                w_issue       = mem_req_val_o && mem_req_rdy_i;
                up_req_rdy_o  = w_issue;
                w_capture     = w_issue && up_req_val_i;
                if (w_issue && !up_req_val_i) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Slice state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slice payload; contents are don't-care while EMPTY
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_we    <= up_req_is_write_i;
            r_addr  <= up_req_addr_i;
            r_wdata <= up_req_data_i;
        end
    end

    assign mem_req_we_o    = r_we;
    assign mem_req_addr_o  = r_addr;
    assign mem_req_wdata_o = r_wdata;

`ifdef FALAFEL_MEM_BRIDGE_BYPASS_EN
    logic w_bypass;
    // Empty FIFO: hand the returning word straight through; store it only if not taken
    assign w_bypass      = w_fifo_empty && w_rsp_ok;
    assign up_rsp_val_o  = !w_fifo_empty || w_bypass;
    assign up_rsp_data_o = w_fifo_empty ? mem_rsp_data_i : r_mem[r_rd_ptr];
    assign w_push        = w_rsp_ok && !(w_bypass && up_rsp_rdy_i);
`else
    assign up_rsp_val_o  = !w_fifo_empty;
    assign up_rsp_data_o = r_mem[r_rd_ptr];
    assign w_push        = w_rsp_ok;
`endif

    assign w_pop      = !w_fifo_empty && up_rsp_rdy_i;
    assign w_overflow = w_push && w_fifo_full && !w_pop;
    assign w_wr_en    = w_push && !w_overflow;

    // Inflight counter, FIFO pointers/occupancy and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err      <= 1'b0;
        end else begin
            case ({w_rd_inc, w_rsp_ok})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_err <= r_err || w_rsp_orphan || w_overflow;
        end
    end

    // Response storage
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= mem_rsp_data_i;
        end
    end

    assign inflight_o = r_inflight;
    assign err_o      = r_err;

endmodule

// File: tb/tb_falafel_mem_bridge.sv
// Self-checking bench for falafel_mem_bridge: scoreboard of bus requests and read data.
module tb_falafel_mem_bridge;

    localparam int unsigned DW = 64;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = $clog2(MO) + 1;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          up_req_val_i;
    logic          up_req_rdy_o;
    logic          up_req_is_write_i;
    logic [DW-1:0] up_req_addr_i;
    logic [DW-1:0] up_req_data_i;
    logic          up_rsp_val_o;
    logic          up_rsp_rdy_i;
    logic [DW-1:0] up_rsp_data_o;
    logic          mem_req_val_o;
    logic          mem_req_rdy_i;
    logic          mem_req_we_o;
    logic [DW-1:0] mem_req_addr_o;
    logic [DW-1:0] mem_req_wdata_o;
    logic          mem_rsp_val_i;
    logic [DW-1:0] mem_rsp_data_i;
    logic [CW-1:0] inflight_o;
    logic          err_o;

    falafel_mem_bridge #(
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .up_req_val_i      (up_req_val_i),
        .up_req_rdy_o      (up_req_rdy_o),
        .up_req_is_write_i (up_req_is_write_i),
        .up_req_addr_i     (up_req_addr_i),
        .up_req_data_i     (up_req_data_i),
        .up_rsp_val_o      (up_rsp_val_o),
        .up_rsp_rdy_i      (up_rsp_rdy_i),
        .up_rsp_data_o     (up_rsp_data_o),
        .mem_req_val_o     (mem_req_val_o),
        .mem_req_rdy_i     (mem_req_rdy_i),
        .mem_req_we_o      (mem_req_we_o),
        .mem_req_addr_o    (mem_req_addr_o),
        .mem_req_wdata_o   (mem_req_wdata_o),
        .mem_rsp_val_i     (mem_rsp_val_i),
        .mem_rsp_data_i    (mem_rsp_data_i),
        .inflight_o        (inflight_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    req_t          op_q[$];
    req_t          req_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] rsp_q[$];
    int            checks   = 0;
    int            errors   = 0;
    int            n_issue  = 0;
    int            base     = 0;
    bit            acc      = 1'b0;
    int            rdy_mode = 1;
    int            rrd_mode = 1;
    int            ret_mode = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory content model
    function automatic logic [DW-1:0] mem_val(input logic [DW-1:0] a);
        if (a == DW'(64'h100)) return DW'(64'hDEAD);
        return a ^ 64'hC0FF_EE00_1234_5678;
    endfunction

    function automatic req_t mk(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.we   = we;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    // Return the oldest outstanding read this cycle
    task automatic ret_next();
        if (rd_q.size() > 0) begin
            mem_rsp_val_i  = 1'b1;
            mem_rsp_data_i = mem_val(rd_q.pop_front());
        end
    endtask

    // Advance to just after the clock edge and apply this cycle's inputs
    task automatic begin_cycle();
        @(posedge clk_i);
        #1;
        if (acc) begin
            void'(op_q.pop_front());
            acc = 1'b0;
        end
        if (op_q.size() > 0) begin
            up_req_val_i      = 1'b1;
            up_req_is_write_i = op_q[0].we;
            up_req_addr_i     = op_q[0].addr;
            up_req_data_i     = op_q[0].data;
        end else begin
            up_req_val_i      = 1'b0;
        end
        mem_req_rdy_i  = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        up_rsp_rdy_i   = (rrd_mode == 2) ? 1'($urandom_range(0, 1)) : (rrd_mode == 1);
        mem_rsp_val_i  = 1'b0;
        mem_rsp_data_i = '0;
        if (ret_mode == 2 && $urandom_range(0, 2) != 0) ret_next();
    endtask

    // Mid-cycle sampling: bus order, accept capture, response data
    task automatic mid();
        req_t e;
        @(negedge clk_i);
        if (rst_i) return;
        if (mem_req_val_o && mem_req_rdy_i) begin
            n_issue++;
            if (req_q.size() == 0) begin
                check("bus_unexpected", DW'(1), DW'(0));
            end else begin
                e = req_q.pop_front();
                check("bus_we", DW'(mem_req_we_o), DW'(e.we));
                check("bus_addr", mem_req_addr_o, e.addr);
                if (e.we) check("bus_wdata", mem_req_wdata_o, e.data);
                else begin
                    rd_q.push_back(e.addr);
                    rsp_q.push_back(mem_val(e.addr));
                end
            end
        end
        if (up_req_val_i && up_req_rdy_o) begin
            req_q.push_back(mk(up_req_is_write_i, up_req_addr_i, up_req_data_i));
            acc = 1'b1;
        end
        if (up_rsp_val_o && up_rsp_rdy_i) begin
            if (rsp_q.size() == 0) check("rsp_unexpected", DW'(1), DW'(0));
            else check("rsp_data", up_rsp_data_o, rsp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        begin_cycle();
        rst_i         = 1'b1;
        mem_rsp_val_i = 1'b0;
        up_req_val_i  = 1'b0;
        op_q.delete();
        req_q.delete();
        rd_q.delete();
        rsp_q.delete();
        acc = 1'b0;
        mid();
        begin_cycle();
        rst_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string t);
        check({t, "_req_rdy"}, DW'(up_req_rdy_o), DW'(1));
        check({t, "_mem_val"}, DW'(mem_req_val_o), DW'(0));
        check({t, "_rsp_val"}, DW'(up_rsp_val_o), DW'(0));
        check({t, "_inflight"}, DW'(inflight_o), DW'(0));
        check({t, "_err"}, DW'(err_o), DW'(0));
    endtask

    task automatic drain(input string t, input int budget);
        int n = 0;
        while ((op_q.size() > 0 || req_q.size() > 0 || rd_q.size() > 0 || rsp_q.size() > 0) && n < budget) begin
            begin_cycle();
            mid();
            n++;
        end
        check({t, "_drain_timeout"}, DW'(n < budget), DW'(1));
        begin_cycle();
        mid();
        check({t, "_inflight_end"}, DW'(inflight_o), DW'(0));
        check({t, "_rsp_val_end"}, DW'(up_rsp_val_o), DW'(0));
        check({t, "_err_end"}, DW'(err_o), DW'(0));
    endtask

    initial begin
        rst_i = 1'b1; up_req_val_i = 1'b0; up_req_is_write_i = 1'b0;
        up_req_addr_i = '0; up_req_data_i = '0; up_rsp_rdy_i = 1'b0;
        mem_req_rdy_i = 1'b0; mem_rsp_val_i = 1'b0; mem_rsp_data_i = '0;

        // Reset state
        do_reset();
        mid();
        check_reset_vals("rst0");

        // Single read with 3-cycle memory latency
        rdy_mode = 1; rrd_mode = 0; ret_mode = 0;
        op_q.push_back(mk(1'b0, DW'(64'h100), '0));
        begin_cycle(); mid();
        check("t1_acc", DW'(up_req_rdy_o), DW'(1));
        check("t1_val_pre", DW'(mem_req_val_o), DW'(0));
        begin_cycle(); mid();
        check("t1_req_val", DW'(mem_req_val_o), DW'(1));
        check("t1_req_addr", mem_req_addr_o, DW'(64'h100));
        check("t1_inflight0", DW'(inflight_o), DW'(0));
        begin_cycle(); mid();
        check("t1_inflight1", DW'(inflight_o), DW'(1));
        begin_cycle(); mid();
        begin_cycle(); ret_next(); mid();
`ifdef FALAFEL_MEM_BRIDGE_BYPASS_EN
        check("t1_bypass_val", DW'(up_rsp_val_o), DW'(1));
        check("t1_bypass_data", up_rsp_data_o, DW'(64'hDEAD));
`else
        check("t1_no_bypass", DW'(up_rsp_val_o), DW'(0));
`endif
        begin_cycle(); mid();
        check("t1_rsp_val", DW'(up_rsp_val_o), DW'(1));
        check("t1_rsp_data", up_rsp_data_o, DW'(64'hDEAD));
        check("t1_inflight2", DW'(inflight_o), DW'(0));
        begin_cycle(); up_rsp_rdy_i = 1'b1; mid();
        begin_cycle(); mid();
        check("t1_rsp_done", DW'(up_rsp_val_o), DW'(0));

        // Credit limit: 6 reads, memory silent
        base = n_issue;
        for (int i = 0; i < 6; i++) op_q.push_back(mk(1'b0, DW'(64'h200 + 8 * i), '0));
        repeat (12) begin begin_cycle(); mid(); end
        check("t2_issued", DW'(n_issue - base), DW'(4));
        check("t2_inflight", DW'(inflight_o), DW'(4));
        check("t2_req_rdy", DW'(up_req_rdy_o), DW'(0));
        check("t2_mem_val", DW'(mem_req_val_o), DW'(0));
        check("t2_pending", DW'(op_q.size()), DW'(1));
        begin_cycle(); ret_next(); mid();
        check("t2_ret_val", DW'(mem_req_val_o), DW'(0));
        begin_cycle(); mid();
        check("t2_inflight3", DW'(inflight_o), DW'(3));
        check("t2_buffered", DW'(up_rsp_val_o), DW'(1));
        check("t2_no_credit", DW'(mem_req_val_o), DW'(0));
        begin_cycle(); up_rsp_rdy_i = 1'b1; mid();
        check("t2_pop_cycle", DW'(mem_req_val_o), DW'(0));
        begin_cycle(); mid();
        check("t2_resume", DW'(mem_req_val_o), DW'(1));
        rrd_mode = 1; ret_mode = 2;
        drain("t2", 200);
        check("t2_total", DW'(n_issue - base), DW'(6));

        // Write held under bus backpressure
        rdy_mode = 0; ret_mode = 0; base = n_issue;
        op_q.push_back(mk(1'b1, DW'(64'h40), DW'(64'h1234)));
        begin_cycle(); mid();
        for (int i = 0; i < 5; i++) begin
            begin_cycle(); mid();
            check("t3_val", DW'(mem_req_val_o), DW'(1));
            check("t3_we", DW'(mem_req_we_o), DW'(1));
            check("t3_addr", mem_req_addr_o, DW'(64'h40));
            check("t3_wdata", mem_req_wdata_o, DW'(64'h1234));
        end
        rdy_mode = 1;
        begin_cycle(); mid();
        begin_cycle(); mid();
        check("t3_issued", DW'(n_issue - base), DW'(1));
        check("t3_val_after", DW'(mem_req_val_o), DW'(0));
        check("t3_inflight", DW'(inflight_o), DW'(0));
        check("t3_no_rsp", DW'(up_rsp_val_o), DW'(0));

        // Interleaved traffic with random handshakes
        rdy_mode = 2; rrd_mode = 2; ret_mode = 2;
        op_q.push_back(mk(1'b1, DW'(64'h80), DW'(64'hAAAA)));
        op_q.push_back(mk(1'b0, DW'(64'h88), '0));
        op_q.push_back(mk(1'b1, DW'(64'h90), DW'(64'hBBBB)));
        op_q.push_back(mk(1'b0, DW'(64'h98), '0));
        for (int i = 0; i < 24; i++)
            op_q.push_back(mk(1'($urandom_range(0, 1)), DW'({$urandom_range(0, 255), 3'b000}), {$urandom, $urandom}));
        drain("t4", 2000);

        // Orphan response sets sticky error
        rdy_mode = 1; rrd_mode = 1; ret_mode = 0;
        begin_cycle(); mem_rsp_val_i = 1'b1; mem_rsp_data_i = DW'(64'hBAD); mid();
        check("t5_err_pre", DW'(err_o), DW'(0));
        begin_cycle(); mid();
        check("t5_err", DW'(err_o), DW'(1));
        check("t5_fifo_empty", DW'(up_rsp_val_o), DW'(0));
        repeat (3) begin begin_cycle(); mid(); end
        check("t5_err_sticky", DW'(err_o), DW'(1));
        do_reset(); mid();
        check("t5_err_clr", DW'(err_o), DW'(0));

        // Reset with 2 reads in flight and 1 buffered
        rrd_mode = 0;
        for (int i = 0; i < 3; i++) op_q.push_back(mk(1'b0, DW'(64'h300 + 8 * i), '0));
        repeat (6) begin begin_cycle(); mid(); end
        check("t6_inflight3", DW'(inflight_o), DW'(3));
        begin_cycle(); ret_next(); mid();
        begin_cycle(); mid();
        check("t6_inflight2", DW'(inflight_o), DW'(2));
        check("t6_buffered", DW'(up_rsp_val_o), DW'(1));
        do_reset(); mid();
        check_reset_vals("t6");
        begin_cycle(); mem_rsp_val_i = 1'b1; mem_rsp_data_i = DW'(64'h55); mid();
        begin_cycle(); mid();
        check("t6_late_rsp_err", DW'(err_o), DW'(1));
        check("t6_late_rsp_drop", DW'(up_rsp_val_o), DW'(0));
        do_reset(); mid();
        check_reset_vals("rst_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
